// File: rtl/pid_multi_axis.sv
// pid_multi_axis: time-multiplexed N-channel PID rate controller, one shared multiplier.
// Build option PID_ANTI_WINDUP_EN: integrator clamp to +/-I_LIMIT plus saturation freeze.
module pid_multi_axis #(
    parameter int     N_CH      = 3,
    parameter int     WIDTH     = 36,
    parameter int     GAIN_W    = 16,
    parameter int     GAIN_FRAC = 8,
    parameter longint I_LIMIT   = 1073741824
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clr_state,
    input  logic [N_CH*WIDTH-1:0]  setpoint,
    input  logic [N_CH*WIDTH-1:0]  measured,
    input  logic [N_CH*GAIN_W-1:0] kp,
    input  logic [N_CH*GAIN_W-1:0] ki,
    input  logic [N_CH*GAIN_W-1:0] kd,
    output logic [N_CH*WIDTH-1:0]  rate_out,
    output logic                   valid,
    output logic                   busy
);
    localparam int PW    = WIDTH + GAIN_W;
    localparam int ACC_W = PW + 2;
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_CH - 1);
    localparam logic signed [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINW = ~MAXW;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(MAXW);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(MINW);
`ifdef PID_ANTI_WINDUP_EN
    localparam bit WIND_EN = 1'b1;
`else
    localparam bit WIND_EN = 1'b0;
`endif
    localparam logic signed [ACC_W-1:0] I_HI = WIND_EN ? ACC_W'(I_LIMIT) : MAXV;
    localparam logic signed [ACC_W-1:0] I_LO = WIND_EN ? -I_HI : MINV;

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_P, S_I, S_D, S_OUT, S_DONE
    } state_t;

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [WIDTH-1:0] v);
        return ACC_W'(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] lim(
        input logic signed [ACC_W-1:0] v,
        input logic signed [ACC_W-1:0] lo,
        input logic signed [ACC_W-1:0] hi
    );
        logic signed [ACC_W-1:0] c;
        c = (v > hi) ? hi : ((v < lo) ? lo : v);
        return c[WIDTH-1:0];
    endfunction

    state_t state, nxt;

    logic signed [WIDTH-1:0]  sp_q   [N_CH];
    logic signed [WIDTH-1:0]  meas_q [N_CH];
    logic signed [GAIN_W-1:0] kp_q   [N_CH];
    logic signed [GAIN_W-1:0] ki_q   [N_CH];
    logic signed [GAIN_W-1:0] kd_q   [N_CH];
    logic signed [WIDTH-1:0]  integ  [N_CH];
    logic signed [WIDTH-1:0]  e_prev [N_CH];
    logic signed [WIDTH-1:0]  out_q  [N_CH];

    logic [CW-1:0]            ch;
    logic signed [WIDTH-1:0]  e_q;
    logic signed [ACC_W-1:0]  acc;
    logic                     clr_pend;

    logic signed [WIDTH-1:0]  e_new, i_sum, de, acc_sat;
    logic signed [GAIN_W-1:0] mul_a;
    logic signed [WIDTH-1:0]  mul_b;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  term;
    logic                     freeze, take, clr_now;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = S_ERR;
            S_ERR:   nxt = S_P;
            S_P:     nxt = S_I;
            S_I:     nxt = S_D;
            S_D:     nxt = S_OUT;
            S_OUT:   nxt = (ch == LAST) ? S_DONE : S_ERR;
            S_DONE:  nxt = start ? S_ERR : S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    assign valid   = (state == S_DONE);
    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign take    = start && (state == S_IDLE || state == S_DONE);
    assign clr_now = (state == S_IDLE && clr_state) ||
                     (state == S_DONE && (clr_state || clr_pend));

    always_comb begin
        e_new   = lim(sx(sp_q[ch]) - sx(meas_q[ch]), MINV, MAXV);
        i_sum   = lim(sx(integ[ch]) + sx(e_new), I_LO, I_HI);
        de      = lim(sx(e_q) - sx(e_prev[ch]), MINV, MAXV);
        acc_sat = lim(acc, MINV, MAXV);
        mul_a   = kp_q[ch];
        mul_b   = e_q;
        unique case (1'b1)
            (state == S_I): begin mul_a = ki_q[ch]; mul_b = integ[ch]; end
            (state == S_D): begin mul_a = kd_q[ch]; mul_b = de; end
            default: ;
        endcase
        prod = mul_a * mul_b;
        term = ACC_W'(prod) >>> GAIN_FRAC;
    end

    // Hold the integrator while the last output is already pinned in the error's direction.
    always_comb begin
        freeze = 1'b0;
`ifdef PID_ANTI_WINDUP_EN
        freeze = (out_q[ch] == MAXW && e_new > 0) ||
                 (out_q[ch] == MINW && e_new < 0);
`endif
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                sp_q[i]   <= '0;
                meas_q[i] <= '0;
                kp_q[i]   <= '0;
                ki_q[i]   <= '0;
                kd_q[i]   <= '0;
                integ[i]  <= '0;
                e_prev[i] <= '0;
                out_q[i]  <= '0;
            end
            ch       <= '0;
            e_q      <= '0;
            acc      <= '0;
            clr_pend <= 1'b0;
        end else begin
            if (take) begin
                for (int i = 0; i < N_CH; i++) begin
                    sp_q[i]   <= setpoint[i*WIDTH +: WIDTH];
                    meas_q[i] <= measured[i*WIDTH +: WIDTH];
                    kp_q[i]   <= kp[i*GAIN_W +: GAIN_W];
                    ki_q[i]   <= ki[i*GAIN_W +: GAIN_W];
                    kd_q[i]   <= kd[i*GAIN_W +: GAIN_W];
                end
                ch <= '0;
            end
            if (clr_now) begin
                for (int i = 0; i < N_CH; i++) begin
                    integ[i]  <= '0;
                    e_prev[i] <= '0;
                end
            end
            if (busy && clr_state)   clr_pend <= 1'b1;
            else if (state == S_DONE) clr_pend <= 1'b0;
            case (state)
                S_ERR: begin
                    e_q <= e_new;
                    if (!freeze) integ[ch] <= i_sum;
                end
                S_P: acc <= term;
                S_I: acc <= acc + term;
                S_D: begin
                    acc        <= acc + term;
                    e_prev[ch] <= e_q;
                end
                S_OUT: begin
                    out_q[ch] <= acc_sat;
                    if (ch != LAST) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign rate_out[g*WIDTH +: WIDTH] = out_q[g];
    end
endmodule

// File: tb/tb_pid_multi_axis.sv
// tb_pid_multi_axis: directed checks of pid_multi_axis (N_CH=3, WIDTH=36, I_LIMIT=50).
// Anti-windup expectations follow whether PID_ANTI_WINDUP_EN is defined for the build.
module tb_pid_multi_axis;
    logic          sys_clk = 1'b0;
    logic          rst, start, clr_state;
    logic [107:0]  setpoint, measured, rate_out;
    logic [47:0]   kp, ki, kd;
    logic          valid, busy;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc, bc, nv;

    always #5 sys_clk = ~sys_clk;

    pid_multi_axis #(.N_CH(3), .WIDTH(36), .GAIN_W(16), .GAIN_FRAC(8), .I_LIMIT(50)) dut (
        .sys_clk(sys_clk), .rst(rst), .start(start), .clr_state(clr_state),
        .setpoint(setpoint), .measured(measured), .kp(kp), .ki(ki), .kd(kd),
        .rate_out(rate_out), .valid(valid), .busy(busy)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] word(input int c);
        logic signed [35:0] w;
        w = rate_out[c*36 +: 36];
        return 64'(w);
    endfunction

    task automatic set_ch(input int c, input longint sp, input longint ms,
                          input int p, input int i, input int d);
        setpoint[c*36 +: 36] = sp[35:0];
        measured[c*36 +: 36] = ms[35:0];
        kp[c*16 +: 16] = p[15:0];
        ki[c*16 +: 16] = i[15:0];
        kd[c*16 +: 16] = d[15:0];
    endtask

    task automatic zero_all();
        setpoint = '0; measured = '0; kp = '0; ki = '0; kd = '0;
    endtask

    task automatic pulse_clr();
        @(negedge sys_clk); clr_state = 1'b1;
        @(posedge sys_clk); #1 clr_state = 1'b0;
    endtask

    // what: 0 none, 1 start pulse, 2 clr_state pulse, driven during cycle 'at'
    task automatic run(input int at, input int what, output int c, output int b);
        @(negedge sys_clk); start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
        c = 1; b = 0;
        while (!valid && c < 40) begin
            if (busy) b++;
            if (c == at) begin
                @(negedge sys_clk);
                if (what == 1) start = 1'b1;
                if (what == 2) clr_state = 1'b1;
            end
            @(posedge sys_clk); #1;
            start = 1'b0; clr_state = 1'b0;
            c++;
        end
        chk("valid_seen", valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; clr_state = 1'b0;
        zero_all();
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_out0", word(0), 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge sys_clk); rst = 1'b0;

        set_ch(0, 100, 40, 256, 0, 0);
        run(-1, 0, cyc, bc);
        chk("p_latency", cyc, 16);
        chk("p_busy_cycles", bc, 15);
        chk("p_out0", word(0), 60);
        chk("p_out1", word(1), 0);
        chk("p_out2", word(2), 0);
        @(posedge sys_clk); #1;
        chk("p_valid_pulse", valid, 0);
        chk("p_busy_after", busy, 0);

        zero_all(); pulse_clr();
        set_ch(1, 10, 0, 0, 256, 0);
        run(-1, 0, cyc, bc); chk("i_run1", word(1), 10);
        run(-1, 0, cyc, bc); chk("i_run2", word(1), 20);
        run(-1, 0, cyc, bc); chk("i_run3", word(1), 30);
        chk("i_ch0_idle", word(0), 0);
        pulse_clr();
        run(-1, 0, cyc, bc); chk("i_after_clr", word(1), 10);

        zero_all(); pulse_clr();
        set_ch(2, 30, 0, 0, 256, 0);
`ifdef PID_ANTI_WINDUP_EN
        run(-1, 0, cyc, bc); chk("aw_run1", word(2), 30);
        run(-1, 0, cyc, bc); chk("aw_run2", word(2), 50);
        run(-1, 0, cyc, bc); chk("aw_run3", word(2), 50);
`else
        run(-1, 0, cyc, bc); chk("aw_run1", word(2), 30);
        run(-1, 0, cyc, bc); chk("aw_run2", word(2), 60);
        run(-1, 0, cyc, bc); chk("aw_run3", word(2), 90);
`endif

        zero_all(); pulse_clr();
        set_ch(0, 10, 0, 0, 0, 256);
        run(-1, 0, cyc, bc); chk("d_first", word(0), 10);
        set_ch(0, 25, 0, 0, 0, 256);
        run(-1, 0, cyc, bc); chk("d_second", word(0), 15);
        pulse_clr();
        set_ch(0, 10, 0, 0, 0, -256);
        run(-1, 0, cyc, bc); chk("d_negative", word(0), -10);

        zero_all(); pulse_clr();
        set_ch(0, 0, 3, 128, 0, 0);
        run(-1, 0, cyc, bc); chk("p_trunc_neg", word(0), -2);

        zero_all(); pulse_clr();
        set_ch(0, 64'sd17179869184, -64'sd17179869184, 256, 0, 0);
        run(-1, 0, cyc, bc); chk("sat_err_clamp", word(0), 64'sd34359738367);
        set_ch(0, 64'sd17179869184, -64'sd17179869184, 32767, 0, 0);
        run(-1, 0, cyc, bc); chk("sat_pos", word(0), 64'sd34359738367);
        set_ch(0, -64'sd17179869184, 64'sd17179869184, 32767, 0, 0);
        run(-1, 0, cyc, bc); chk("sat_neg", word(0), -64'sd34359738368);

        zero_all(); pulse_clr();
        set_ch(0, 7, 0, 256, 0, 0);
        run(5, 1, cyc, bc);
        chk("ign_latency", cyc, 16);
        chk("ign_out0", word(0), 7);
        nv = 1;
        repeat (25) begin
            @(posedge sys_clk); #1;
            if (valid) nv++;
        end
        chk("ign_valid_count", nv, 1);

        set_ch(0, 9, 0, 256, 0, 0);
        @(negedge sys_clk); start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
        cyc = 1;
        while (cyc < 7) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        rst = 1'b1; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out0", word(0), 0);
        @(negedge sys_clk); rst = 1'b0;
        nv = 0;
        repeat (25) begin
            @(posedge sys_clk); #1;
            if (valid) nv++;
        end
        chk("mid_rst_no_valid", nv, 0);
        run(-1, 0, cyc, bc); chk("post_rst_run", word(0), 9);

        zero_all(); pulse_clr();
        set_ch(1, 10, 0, 0, 256, 0);
        run(-1, 0, cyc, bc); chk("cb_run1", word(1), 10);
        run(3, 2, cyc, bc);  chk("cb_old_state", word(1), 20);
        run(-1, 0, cyc, bc); chk("cb_cleared", word(1), 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
